// File: rtl/serial_out.sv
// serial_out: parallel byte to async-serial frame transmitter.
// Frame = start bit (0), 8 data bits LSB first, STOP_BITS stop bits (1).
// A one-byte holding register lets the next byte queue so that frames
// can go out back to back with no idle gap.
module serial_out #(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] byte_in_i,
    input  logic       load_i,
    output logic       ready_o,
    output logic       tx_d_o,
    output logic       busy_o,
    output logic       overrun_o
);

    localparam int unsigned TMR_W      = $clog2(CLKS_PER_BIT) + 1;
    localparam int unsigned IDX_W      = 3;
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(7);
    localparam logic             STOP_LAST  = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         hold_q, hold_d;
    logic               hold_v_q, hold_v_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               stop_cnt_q, stop_cnt_d;
    logic               tx_q, tx_d;
    logic               busy_q;
    logic               ready_q;
    logic               overrun_q, overrun_d;

    logic               accept_c;
    logic               timer_zero_c;
    logic               frame_end_c;

    // Handshake and timing qualifiers shared by the next-state and output logic
    assign accept_c     = load_i && !hold_v_q;
    assign timer_zero_c = (timer_q == '0);
    assign frame_end_c  = (state_q == STOP) && timer_zero_c && (stop_cnt_q == STOP_LAST);

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: walk start, data, stop; chain straight into START when a byte is waiting
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_c) state_d = START;
            end
            START: begin
                if (timer_zero_c) state_d = DATA;
            end
            DATA: begin
                if (timer_zero_c && (idx_q == IDX_LAST)) state_d = STOP;
            end
            STOP: begin
                if (frame_end_c) state_d = (hold_v_q || accept_c) ? START : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath / output next values: bit timer, shifter, holding register, line level
    always_comb begin
        shift_d    = shift_q;
        hold_d     = hold_q;
        hold_v_d   = hold_v_q;
        timer_d    = timer_q;
        idx_d      = idx_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        overrun_d  = load_i && hold_v_q;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (accept_c) begin
                    shift_d = byte_in_i;
                    tx_d    = 1'b0;
                    timer_d = TMR_RELOAD;
                end
            end
            START: begin
                if (timer_zero_c) begin
                    tx_d    = shift_q[0];
                    idx_d   = '0;
                    timer_d = TMR_RELOAD;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            DATA: begin
                if (timer_zero_c) begin
                    timer_d = TMR_RELOAD;
                    if (idx_q != IDX_LAST) begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                        idx_d   = idx_q + IDX_W'(1);
                    end else begin
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            STOP: begin
                if (timer_zero_c) begin
                    timer_d = TMR_RELOAD;
                    if (stop_cnt_q == STOP_LAST) begin
                        if (hold_v_q) begin
                            shift_d  = hold_q;
                            hold_v_d = 1'b0;
                            tx_d     = 1'b0;
                        end else if (accept_c) begin
                            shift_d = byte_in_i;
                            tx_d    = 1'b0;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: tx_d = 1'b1;
        endcase

        // Mid-frame arrivals queue in HOLD; the frame-end edge instead uses the bypass path above
        if ((state_q != IDLE) && !frame_end_c && accept_c) begin
            hold_d   = byte_in_i;
            hold_v_d = 1'b1;
        end
    end

    // Datapath and registered outputs; reset aborts any frame and drops the queued byte
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            shift_q    <= '0;
            hold_q     <= '0;
            hold_v_q   <= 1'b0;
            timer_q    <= '0;
            idx_q      <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            overrun_q  <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            hold_v_q   <= hold_v_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= (state_d != IDLE);
            ready_q    <= !hold_v_d;
            overrun_q  <= overrun_d;
        end
    end

    assign tx_d_o    = tx_q;
    assign busy_o    = busy_q;
    assign ready_o   = ready_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_serial_out.sv
// Bench for serial_out: two instances (4 clk/bit + 1 stop, 1 clk/bit + 2 stop)
// compared cycle by cycle against an ideal line waveform built from frame rules.
module tb_serial_out;

    logic       clk;
    logic       rst_a, rst_b;
    logic [7:0] byte_in;
    logic       load_a, load_b;
    logic       ready_a, tx_a, busy_a, ovr_a;
    logic       ready_b, tx_b, busy_b, ovr_b;

    int checks   = 0;
    int failures = 0;

    logic       wave_q[$];
    int         ld_k_q[$];
    logic [7:0] ld_b_q[$];

    serial_out #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
        .clk_i(clk), .rst_n_i(rst_a), .byte_in_i(byte_in), .load_i(load_a),
        .ready_o(ready_a), .tx_d_o(tx_a), .busy_o(busy_a), .overrun_o(ovr_a)
    );

    serial_out #(.CLKS_PER_BIT(1), .STOP_BITS(2)) dut_b (
        .clk_i(clk), .rst_n_i(rst_b), .byte_in_i(byte_in), .load_i(load_b),
        .ready_o(ready_b), .tx_d_o(tx_b), .busy_o(busy_b), .overrun_o(ovr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input logic obs, input logic want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, want);
        end
    endtask

    // Ideal frame: start 0, data LSB first, stop bits 1, each bit held c cycles
    task automatic push_frame(input logic [7:0] b, input int c, input int s);
        for (int i = 0; i < 9 + s; i++) begin
            logic v;
            if (i == 0)      v = 1'b0;
            else if (i <= 8) v = b[i-1];
            else             v = 1'b1;
            for (int j = 0; j < c; j++) wave_q.push_back(v);
        end
    endtask

    task automatic plan_load(input int k, input logic [7:0] b);
        ld_k_q.push_back(k);
        ld_b_q.push_back(b);
    endtask

    // Runs n sampled cycles (k = 0 is the negedge after the first accepting edge).
    // A load planned at k is presented during cycle k and taken at edge k+1.
    task automatic run_case(input bit sel, input int n, input int rdy_lo,
                            input int rdy_hi, input int ovr_k);
        for (int k = -1; k < n; k++) begin
            if (k >= 0) begin
                logic o_tx, o_busy, o_rdy, o_ovr;
                o_tx   = sel ? tx_b    : tx_a;
                o_busy = sel ? busy_b  : busy_a;
                o_rdy  = sel ? ready_b : ready_a;
                o_ovr  = sel ? ovr_b   : ovr_a;
                chk("tx_d",    k, o_tx,   (k < wave_q.size()) ? wave_q[k] : 1'b1);
                chk("busy",    k, o_busy, k < wave_q.size());
                chk("ready",   k, o_rdy,  !(k >= rdy_lo && k < rdy_hi));
                chk("overrun", k, o_ovr,  k == ovr_k);
            end
            load_a = 1'b0;
            load_b = 1'b0;
            for (int i = 0; i < ld_k_q.size(); i++) begin
                if (ld_k_q[i] == k) begin
                    byte_in = ld_b_q[i];
                    if (sel) load_b = 1'b1; else load_a = 1'b1;
                end
            end
            @(negedge clk);
        end
        load_a = 1'b0;
        load_b = 1'b0;
        wave_q.delete();
        ld_k_q.delete();
        ld_b_q.delete();
    endtask

    task automatic chk_reset_outputs(input bit sel, input string tag);
        chk({tag, "_tx"},    0, sel ? tx_b    : tx_a,    1'b1);
        chk({tag, "_ready"}, 0, sel ? ready_b : ready_a, 1'b1);
        chk({tag, "_busy"},  0, sel ? busy_b  : busy_a,  1'b0);
        chk({tag, "_ovr"},   0, sel ? ovr_b   : ovr_a,   1'b0);
    endtask

    initial begin
        logic [7:0] r0, r1;
        int d;
        rst_a = 1'b0; rst_b = 1'b0;
        load_a = 1'b0; load_b = 1'b0; byte_in = 8'h00;
        repeat (2) @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (3) @(negedge clk);

        // Reset mid-idle: outputs take reset values without a clock edge
        #2;
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        chk_reset_outputs(1'b0, "rst_idle_a");
        chk_reset_outputs(1'b1, "rst_idle_b");
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);

        // Single 0xA5 frame, 4 clk/bit
        push_frame(8'hA5, 4, 1);
        plan_load(-1, 8'hA5);
        run_case(1'b0, 44, -1, -1, -1);

        // Back-to-back 0x00 then 0xFF queued at edge 5
        push_frame(8'h00, 4, 1);
        push_frame(8'hFF, 4, 1);
        plan_load(-1, 8'h00);
        plan_load(4, 8'hFF);
        run_case(1'b0, 84, 5, 40, -1);

        // Overrun: 0x11 in flight, 0x22 queued, 0x33 discarded
        push_frame(8'h11, 4, 1);
        push_frame(8'h22, 4, 1);
        plan_load(-1, 8'h11);
        plan_load(2, 8'h22);
        plan_load(9, 8'h33);
        run_case(1'b0, 84, 3, 40, 10);

        // Reset mid-frame: 0xA5 in flight with 0x77 queued, reset after 15 cycles
        push_frame(8'hA5, 4, 1);
        plan_load(-1, 8'hA5);
        plan_load(3, 8'h77);
        run_case(1'b0, 15, 4, 40, -1);
        #2;
        rst_a = 1'b0;
        #1;
        chk_reset_outputs(1'b0, "rst_frame");
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        push_frame(8'h5A, 4, 1);
        plan_load(-1, 8'h5A);
        run_case(1'b0, 45, -1, -1, -1);

        // 1 clk/bit, 2 stop bits: 0x3C, next byte loaded on the final stop edge
        push_frame(8'h3C, 1, 2);
        push_frame(8'hC3, 1, 2);
        plan_load(-1, 8'h3C);
        plan_load(10, 8'hC3);
        run_case(1'b1, 25, -1, -1, -1);

        // Randomized back-to-back pairs on both configurations
        for (int it = 0; it < 4; it++) begin
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            d  = int'($urandom_range(1, 39));
            push_frame(r0, 4, 1);
            push_frame(r1, 4, 1);
            plan_load(-1, r0);
            plan_load(d - 1, r1);
            run_case(1'b0, 84, d, 40, -1);

            r0 = 8'($urandom);
            r1 = 8'($urandom);
            d  = int'($urandom_range(1, 10));
            push_frame(r0, 1, 2);
            push_frame(r1, 1, 2);
            plan_load(-1, r0);
            plan_load(d - 1, r1);
            run_case(1'b1, 25, d, 11, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_out.md
# serial_out

Byte-to-serial transmitter for the Serial-to-SPI path: accepts parallel bytes over a LOAD/READY handshake and shifts each out on TX_D as an async-serial frame. Frame is one start bit (0), eight data bits LSB first, and STOP_BITS stop bits (1). A one-byte holding register lets a second byte queue during a frame so consecutive frames go out with no idle gap. Sits between the parallel byte source and the serial line, on the opposite end of the line from the serial receiver.

## Interface
- CLKS_PER_BIT, 1: CLK cycles per serial bit. Legal range is 1..65535; counter width is $clog2(CLKS_PER_BIT)+1.
- STOP_BITS, 1: number of stop bits. Legal values are 1 or 2.

- CLK  input  1  system clock; all logic on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- BYTEIN  input  8  byte to transmit; sampled on an edge where LOAD && READY.
- LOAD  input  1  byte-valid strobe from the source.
- READY  output  1  1 = holding register empty, byte can be accepted.
- TX_D  output  1  serial line, registered; idles high.
- BUSY  output  1  1 whenever a frame is in progress (state != IDLE).
- OVERRUN  output  1  one-cycle pulse when LOAD=1 arrives while READY=0; that byte is discarded.

## Operation
- Registers:
  - 8-bit shifter
  - 8-bit HOLD plus HOLD_V flag
  - bit timer
  - 3-bit bit index
  - stop-bit counter
  - state: IDLE, START, DATA, STOP
- READY = !HOLD_V.
- IDLE: TX_D=1. On LOAD && READY, BYTEIN loads the shifter directly (bypasses HOLD), TX_D<=0, timer<=CLKS_PER_BIT-1, state<=START.
- START: when timer==0, TX_D<=shifter[0], index<=0, state<=DATA. Otherwise timer decrements.
- DATA: when timer==0:
  - If index<7: shift right, TX_D<=next bit, index++.
  - If index==7: TX_D<=1, state<=STOP.
  - In both cases the timer reloads.
- STOP: lasts STOP_BITS*CLKS_PER_BIT cycles. At the final cycle's edge:
  - If HOLD_V: shifter<=HOLD, HOLD_V<=0, TX_D<=0, state<=START.
  - Else if LOAD && READY: bypass load as in IDLE, go to START.
  - Else: state<=IDLE.
- Non-IDLE states, LOAD && READY: BYTEIN goes to HOLD, HOLD_V<=1. This does not apply at the final STOP edge, which uses the bypass rule above.
- LOAD && !READY: OVERRUN<=1 for one cycle. HOLD is unchanged.
- LOAD is level-qualified. A source holding LOAD high across several edges while READY=1 enqueues one byte per accepting edge; the source must drop LOAD after acceptance.

## Timing
- Reset values, applied asynchronously while RST_N=0: TX_D=1, READY=1, BUSY=0, OVERRUN=0, state=IDLE, HOLD_V=0.
- Reset mid-frame aborts the frame immediately: TX_D returns to 1 and any queued byte is lost.
- Latency: TX_D falls at the same edge that accepts the byte in IDLE. BUSY rises at that edge.
- Frame length: (9+STOP_BITS)*CLKS_PER_BIT cycles from the falling edge of TX_D to the frame-end edge.
- Back-to-back frames: the next start bit begins at the edge ending the last stop bit. The stop-bit high time is exactly STOP_BITS*CLKS_PER_BIT cycles.
- READY falls at the edge HOLD is written and rises at the frame-end edge that moves HOLD into the shifter.
- BUSY falls at the frame-end edge only when nothing is queued or loaded.
- CLKS_PER_BIT=1: every state lasts one cycle per bit; the same rules apply.

## Test plan
- Reset: assert RST_N=0 mid-idle -> TX_D=1, READY=1, BUSY=0, OVERRUN=0 without waiting for a CLK edge.
- Single byte, CLKS_PER_BIT=4, STOP_BITS=1, BYTEIN=0xA5 -> TX_D sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. BUSY is high for 40 cycles, then TX_D stays 1.
- Back-to-back, CLKS_PER_BIT=4: load 0x00, then 0xFF at cycle 5 -> READY low from cycle 5 to cycle 40. Stop bit high for exactly 4 cycles, then start of the 0xFF frame. BUSY never drops between frames.
- Overrun: 0x11 in flight and 0x22 queued, pulse LOAD with 0x33 -> OVERRUN high for 1 cycle. 0x11 then 0x22 are transmitted and 0x33 never appears.
- Reset mid-frame: pulse RST_N low at cycle 15 of an 0xA5 frame -> TX_D=1 immediately, queued byte dropped. A subsequent 0x5A transmits as a complete correct frame.
- CLKS_PER_BIT=1, STOP_BITS=2, BYTEIN=0x3C, plus a simultaneous load at the final stop edge -> 11-cycle frame 0,0,0,1,1,1,1,0,0,1,1. The next start bit follows on the very next cycle.
